// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage of the pipelined MIPS core. Holds the PC, issues
//   word requests to instruction memory over a req/ack handshake, buffers one
//   returned instruction against decode back-pressure, and handles
//   branch/jump redirects (including abandoning an in-flight request).
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST          asynchronous active-low reset
//   IMem_Req     fetch request valid
//   IMem_Addr    word address of the request (bits [1:0] always 0)
//   IMem_Ack     memory response; transfer = IMem_Req & IMem_Ack at an edge
//   IMem_Data    instruction word, valid in the transfer cycle
//   Stall        decode cannot accept a new instruction this cycle
//   Redirect     single-cycle pulse: branch/jump taken, flush and refetch
//   Redirect_PC  new fetch target (bits [1:0] ignored)
//   Instr_out    instruction to decode ([15:0] feeds sign-extension)
//   PCPlus4_out  address of Instr_out plus 4
//   Instr_Valid  Instr_out/PCPlus4_out hold a valid instruction
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic [31:0] Instr_out,
    output logic [31:0] PCPlus4_out,
    output logic        Instr_Valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic [31:0] skid_data_q;   // occupied exactly while state_q == FULL
    logic [31:0] skid_pc4_q;
    logic [31:0] target_q;      // redirect target held while draining

    logic        xfer;
    logic        accept;
    logic [31:0] redir_pc;
    logic [31:0] addr_plus4;

    assign xfer       = req_q & IMem_Ack;
    // Stall only matters when something valid is sitting on the outputs.
    assign accept     = ~valid_q | ~Stall;
    assign redir_pc   = Redirect_PC & WORD_MASK;
    assign addr_plus4 = addr_q + 32'd4;   // wraps naturally at 2^32

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC & WORD_MASK;
            instr_q     <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
            skid_data_q <= '0;
            skid_pc4_q  <= '0;
            target_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Redirect is ignored here; addr_q already holds the PC.
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end

                FETCH: begin
                    if (Redirect) begin
                        valid_q <= 1'b0;
                        if (xfer) begin
                            // Returning word belongs to the wrong path: drop it.
                            addr_q <= redir_pc;
                        end else begin
                            // Memory still owes us a response at addr_q; it must
                            // be collected and discarded before refetching.
                            target_q <= redir_pc;
                            state_q  <= DRAIN;
                        end
                    end else if (xfer) begin
                        if (accept) begin
                            instr_q <= IMem_Data;
                            pc4_q   <= addr_plus4;
                            valid_q <= 1'b1;
                            addr_q  <= addr_plus4;
                        end else begin
                            skid_data_q <= IMem_Data;
                            skid_pc4_q  <= addr_plus4;
                            req_q       <= 1'b0;
                            state_q     <= FULL;
                        end
                    end else if (accept) begin
                        valid_q <= 1'b0;
                    end
                end

                FULL: begin
                    if (Redirect) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= redir_pc;
                        state_q <= FETCH;
                    end else if (!Stall) begin
                        instr_q <= skid_data_q;
                        pc4_q   <= skid_pc4_q;
                        valid_q <= 1'b1;
                        req_q   <= 1'b1;
                        addr_q  <= skid_pc4_q;
                        state_q <= FETCH;
                    end
                end

                DRAIN: begin
                    if (Redirect) begin
                        target_q <= redir_pc;
                    end else if (xfer) begin
                        addr_q  <= target_q;
                        state_q <= FETCH;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign IMem_Req    = req_q;
    assign IMem_Addr   = addr_q;
    assign Instr_out   = instr_q;
    assign PCPlus4_out = pc4_q;
    assign Instr_Valid = valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the pipelined MIPS core, directly upstream of decode and the immediate sign-extension path.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers one returned instruction against decode back-pressure and handles branch/jump redirects.
- Presents Instr_out, whose [15:0] feeds the sign-extend unit, plus PCPlus4_out to decode.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  reset, asynchronous, active-low.
IMem_Req  output  1  fetch request valid.
IMem_Addr  output  32  word address of the request; bits [1:0] always 0.
IMem_Ack  input  1  memory response; a transfer completes on a rising edge where IMem_Req=1 and IMem_Ack=1.
IMem_Data  input  32  instruction word, valid in the transfer cycle.
Stall  input  1  decode cannot accept a new instruction this cycle.
Redirect  input  1  single-cycle pulse: branch/jump taken, flush and refetch.
Redirect_PC  input  32  new fetch target; bits [1:0] forced to 0 internally.
Instr_out  output  32  instruction to decode.
PCPlus4_out  output  32  address of Instr_out plus 4.
Instr_Valid  output  1  Instr_out/PCPlus4_out hold a valid instruction.

Behaviour:
- Reset (RST=0, asynchronous):
  - State IDLE; PC=RESET_PC.
  - IMem_Req=0, IMem_Addr=RESET_PC, Instr_out=0, PCPlus4_out=0, Instr_Valid=0.
  - Skid buffer empty.
  - A response in flight when reset asserts is abandoned.
- All outputs are registered; no combinational path from input to output.
- "Accept" = (Instr_Valid=0) or (Stall=0). Stall has no effect while Instr_Valid=0.
- States:
  - IDLE: first edge after reset release -> FETCH; IMem_Req=1, IMem_Addr=PC.
  - FETCH: IMem_Req=1; IMem_Addr stable until transfer.
    - On transfer with Accept: Instr_out=IMem_Data, PCPlus4_out=IMem_Addr+4, Instr_Valid=1; next IMem_Addr=IMem_Addr+4; stay in FETCH. This sustains 1 instr/cycle when Ack is held high.
    - On transfer without Accept: data and address+4 go to the skid buffer; IMem_Req=0; -> FULL.
    - No transfer and Accept: Instr_Valid=0.
  - FULL: IMem_Req=0; outputs hold.
    - When Stall=0: buffer moves to outputs (Instr_Valid=1); IMem_Req=1 at buffered address+4; -> FETCH.
  - DRAIN: IMem_Req=1 held at the abandoned address until transfer; returned data is discarded; Instr_Valid stays 0.
    - On transfer: IMem_Addr=pending target PC; -> FETCH.
- Redirect takes priority over Stall, Ack and buffer logic in all states except IDLE:
  - Instr_Valid=0 and skid buffer cleared on that edge.
  - FETCH, request pending, no transfer that edge: -> DRAIN; target latched.
  - FETCH with transfer on the same edge: data dropped; IMem_Addr=Redirect_PC; stay in FETCH.
  - FULL: -> FETCH; IMem_Req=1, IMem_Addr=Redirect_PC.
  - DRAIN: target overwritten by the newest Redirect_PC; stay in DRAIN.
  - IDLE: Redirect is ignored.
- Address arithmetic: 32-bit, PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- First-fetch latency: with Ack tied 1, IMem_Req rises 1 cycle after reset release; Instr_Valid rises on the following edge.
- Redirect-to-valid: 2 edges with Ack=1; in DRAIN, 1 extra edge per abandoned response.

Test Plan:
- Streaming:
  - Stimulus: RESET_PC=0, Ack=1, IMem_Data=addr|32'hA500_0000, Stall=0.
  - Response: Instr_out sequence A500_0000, A500_0004, A500_0008..., one per cycle; PCPlus4_out=4,8,12.
- Stall with skid:
  - Stimulus: Stall=1 for 3 cycles while Ack=1.
  - Response: Instr_out holds; exactly one word buffered; IMem_Req=0 during FULL.
  - After Stall drops: buffered word appears next cycle, fetch resumes at +4; no word lost or duplicated.
- Redirect during pending request:
  - Stimulus: Ack=0 with request at 0x10; Redirect to 0x400; Ack=1 two cycles later with data 0xDEAD_BEEF.
  - Response: 0xDEAD_BEEF is never valid; next request is at 0x400.
- Redirect with simultaneous transfer, and redirect while FULL:
  - Response: data dropped; IMem_Addr=Redirect_PC next cycle; Instr_Valid=0 for that cycle.
- Slow memory and wrap:
  - Stimulus: Ack pulsed every 3rd cycle; separately start at 32'hFFFF_FFF8.
  - Response: IMem_Addr stable while waiting; address sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Asynchronous reset mid-stream:
  - Stimulus: assert RST between edges.
  - Response: outputs clear immediately to their reset values; after release, first request at RESET_PC.
